// File: rtl/i2c_slave_regs.sv
// I2C target with a byte-addressed register file. SCL/SDA are oversampled on clk
// and every bus action is decoded from synchronized edges.
module i2c_slave_regs #(
  parameter int NUM_REGS    = 16,
  parameter int PTR_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl,
  inout  wire              sda,
  input  logic [6:0]       slave_addr,
  input  logic [PTR_W-1:0] reg_sel,
  output logic [7:0]       reg_q,
  output logic             wr_evt,
  output logic [PTR_W-1:0] wr_idx,
  output logic [7:0]       wr_dat,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK_CHK, WAIT_STOP
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   rw_q, rw_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   rack_q, rack_d;
  logic                   busy_q, busy_d;
  logic                   wr_evt_q, wr_evt_d;
  logic [PTR_W-1:0]       wr_idx_q, wr_idx_d;
  logic [7:0]             wr_dat_q, wr_dat_d;
  logic [7:0]             reg_q_q, reg_q_d;
  logic [7:0]             regs_q [NUM_REGS];
  logic [7:0]             regs_d [NUM_REGS];

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign rx_byte   = {shift_q[6:0], sda_s};

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    rack_d     = rack_q;
    busy_d     = busy_q;
    wr_evt_d   = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_dat_d   = wr_dat_q;
    regs_d     = regs_q;
    reg_q_d    = regs_q[reg_sel];

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, WAIT_STOP: ;
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                if (rx_byte[7:1] == slave_addr) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = WAIT_STOP;
                end
              end else if (state_q == PTR) begin
                ptr_d   = rx_byte[PTR_W-1:0];
                state_d = PTR_ACK;
              end else begin
                regs_d[ptr_q] = rx_byte;
                wr_evt_d      = 1'b1;
                wr_idx_d      = ptr_q;
                wr_dat_d      = rx_byte;
                ptr_d         = ptr_q + 1'b1;
                state_d       = WDATA_ACK;
              end
            end
          end
        end
        // SDA is always released on entry, so sda_oe_q tells the two ACK falls apart.
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ADDR_ACK && rw_q) begin
                shift_d  = regs_q[ptr_q];
                sda_oe_d = ~regs_q[ptr_q][7];
                state_d  = RDATA;
              end else begin
                state_d = (state_q == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              rack_d    = 1'b0;
              state_d   = RACK_CHK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        RACK_CHK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              rack_d = 1'b1;
              ptr_d  = ptr_q + 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end else if (scl_fall && rack_q) begin
            shift_d   = regs_q[ptr_q];
            sda_oe_d  = ~regs_q[ptr_q][7];
            bit_cnt_d = '0;
            state_d   = RDATA;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      rack_q     <= 1'b0;
      busy_q     <= 1'b0;
      wr_evt_q   <= 1'b0;
      wr_idx_q   <= '0;
      wr_dat_q   <= '0;
      reg_q_q    <= '0;
      // NOTE: the register file is reset because software relies on it reading 0x00 after reset.
      regs_q     <= '{default: '0};
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      rack_q     <= rack_d;
      busy_q     <= busy_d;
      wr_evt_q   <= wr_evt_d;
      wr_idx_q   <= wr_idx_d;
      wr_dat_q   <= wr_dat_d;
      reg_q_q    <= reg_q_d;
      regs_q     <= regs_d;
    end
  end

  assign sda    = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_q  = reg_q_q;
  assign wr_evt = wr_evt_q;
  assign wr_idx = wr_idx_q;
  assign wr_dat = wr_dat_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bus-level bench for i2c_slave_regs: a bit-banged I2C controller plus a register/pointer
// model compares every ACK, read byte, write event and local read.
module tb_i2c_slave_regs;

  localparam int NUM_REGS = 16;
  localparam int PTR_W    = 4;
  localparam logic [6:0] ADDR7 = 7'h11;

  logic             clk = 1'b0;
  logic             rst;
  logic             scl;
  logic             m_low;
  wire              sda;
  logic [6:0]       slave_addr;
  logic [PTR_W-1:0] reg_sel;
  logic [7:0]       reg_q;
  logic             wr_evt;
  logic [PTR_W-1:0] wr_idx;
  logic [7:0]       wr_dat;
  logic             busy;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #10 clk = ~clk;

  i2c_slave_regs #(.NUM_REGS(NUM_REGS), .PTR_W(PTR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .slave_addr(slave_addr),
    .reg_sel(reg_sel), .reg_q(reg_q), .wr_evt(wr_evt), .wr_idx(wr_idx),
    .wr_dat(wr_dat), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]       m_regs [NUM_REGS];
  int               m_ptr;
  logic [7:0]       wq[$];
  logic [PTR_W-1:0] evq_idx[$];
  logic [7:0]       evq_dat[$];
  logic [7:0]       evq_rq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every write strobe is logged with the reg_q seen in the same cycle.
  always @(negedge clk) begin
    if (wr_evt) begin
      evq_idx.push_back(wr_idx);
      evq_dat.push_back(wr_dat);
      evq_rq.push_back(reg_q);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    scl = 1'b0;  wait_clk(4);
    m_low = ~b;  wait_clk(6);
    scl = 1'b1;  wait_clk(5);
    s = sda;     wait_clk(5);
  endtask

  task automatic m_start;
    scl = 1'b0;   wait_clk(4);
    m_low = 1'b0; wait_clk(6);
    scl = 1'b1;   wait_clk(10);
    m_low = 1'b1; wait_clk(10);
  endtask

  task automatic m_stop;
    scl = 1'b0;   wait_clk(4);
    m_low = 1'b1; wait_clk(6);
    scl = 1'b1;   wait_clk(10);
    m_low = 1'b0; wait_clk(10);
  endtask

  task automatic m_write(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic m_read(input logic send_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      b[i] = s;
    end
    bus_bit(~send_ack, s);
  endtask

  task automatic check_local(input int idx, input logic [7:0] exp);
    @(negedge clk) reg_sel = PTR_W'(idx);
    @(negedge clk);
    check("local_reg_q", reg_q, exp);
  endtask

  task automatic do_write(input logic [7:0] ptr_byte);
    logic       ack;
    logic [7:0] old0;
    logic [7:0] rq;
    m_ptr = int'(ptr_byte) % NUM_REGS;
    old0  = m_regs[m_ptr];
    @(negedge clk) reg_sel = PTR_W'(m_ptr);
    m_start;
    m_write({ADDR7, 1'b0}, ack); check("w_addr_ack", ack, 1);
    m_write(ptr_byte, ack);      check("w_ptr_ack", ack, 1);
    for (int k = 0; k < wq.size(); k++) begin
      m_write(wq[k], ack);
      check("w_data_ack", ack, 1);
      check("w_evt_count", evq_idx.size(), 1);
      if (evq_idx.size() != 0) begin
        check("w_evt_idx", evq_idx.pop_front(), m_ptr);
        check("w_evt_dat", evq_dat.pop_front(), wq[k]);
        rq = evq_rq.pop_front();
        if (k == 0) begin
          check("w_regq_old", rq, old0);
          check("w_regq_new", reg_q, wq[k]);
        end
      end
      m_regs[m_ptr] = wq[k];
      m_ptr = (m_ptr + 1) % NUM_REGS;
    end
    check("w_busy", busy, 1);
    m_stop;
    check("w_busy_after_stop", busy, 0);
    check("w_no_extra_evt", evq_idx.size(), 0);
  endtask

  task automatic do_read(input bit set_ptr, input logic [7:0] ptr_byte, input int n);
    logic       ack;
    logic [7:0] b;
    m_start;
    if (set_ptr) begin
      m_write({ADDR7, 1'b0}, ack); check("r_addrw_ack", ack, 1);
      m_write(ptr_byte, ack);      check("r_ptr_ack", ack, 1);
      m_ptr = int'(ptr_byte) % NUM_REGS;
      m_start;
    end
    m_write({ADDR7, 1'b1}, ack); check("r_addr_ack", ack, 1);
    for (int k = 0; k < n; k++) begin
      m_read(k < n - 1, b);
      check("r_data", b, m_regs[m_ptr]);
      if (k < n - 1) m_ptr = (m_ptr + 1) % NUM_REGS;
    end
    check("r_sda_rel_nack", sda, 1);
    scl = 1'b0;
    wait_clk(8);
    check("r_sda_rel_low", sda, 1);
    check("r_busy", busy, 1);
    m_stop;
    check("r_busy_after_stop", busy, 0);
    check("r_no_evt", evq_idx.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t exceeded limit 2000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] addr_w;
    int         op;
    int         n;
    int         idx;

    rst = 1'b1; scl = 1'b1; m_low = 1'b0; slave_addr = ADDR7; reg_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(2);

    check("rst_busy", busy, 0);
    check("rst_wr_evt", wr_evt, 0);
    check("rst_wr_idx", wr_idx, 0);
    check("rst_wr_dat", wr_dat, 0);
    check("rst_reg_q", reg_q, 0);
    check("rst_sda", sda, 1);

    // Single write of 0xAA to register 0, then read it back over a repeated START.
    wq.delete(); wq.push_back(8'hAA);
    do_write(8'h00);
    check_local(0, m_regs[0]);
    do_read(1, 8'h00, 1);

    // Foreign address: no ACK, following byte ignored, busy never rises.
    m_start;
    m_write(8'h24, ack); check("mm_addr_nack", ack, 0);
    check("mm_busy", busy, 0);
    m_write(8'h00, ack); check("mm_byte_ignored", ack, 0);
    m_stop;
    check("mm_busy_after", busy, 0);
    check("mm_no_evt", evq_idx.size(), 0);

    // Burst wrap from register 15; pointer then rests at 1.
    wq.delete(); wq.push_back(8'h5C);
    do_write(8'h01);
    wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
    do_write(8'h0F);
    check_local(15, m_regs[15]);
    check_local(0, m_regs[0]);
    do_read(0, 8'h00, 1);
    do_read(1, 8'h0F, 2);

    // STOP after four data bits discards the partial byte and keeps the pointer.
    wq.delete(); wq.push_back(8'h3C);
    do_write(8'h03);
    m_start;
    m_write({ADDR7, 1'b0}, ack); check("ab_addr_ack", ack, 1);
    m_write(8'h03, ack);         check("ab_ptr_ack", ack, 1);
    m_ptr = 3;
    for (int i = 0; i < 4; i++) bus_bit(i[0], s);
    m_stop;
    check("ab_no_evt", evq_idx.size(), 0);
    check("ab_busy", busy, 0);
    check_local(3, m_regs[3]);
    do_read(0, 8'h00, 1);

    for (int it = 0; it < 16; it++) begin
      op = $urandom_range(0, 2);
      n  = $urandom_range(1, 4);
      case (op)
        0: begin
          wq.delete();
          for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
          do_write(8'($urandom));
        end
        1:       do_read(1, 8'($urandom), n);
        default: do_read(0, 8'h00, n);
      endcase
      idx = $urandom_range(0, NUM_REGS - 1);
      check_local(idx, m_regs[idx]);
    end

    // Reset while the target holds the address ACK low.
    addr_w = {ADDR7, 1'b0};
    m_start;
    for (int i = 7; i >= 0; i--) bus_bit(addr_w[i], s);
    scl = 1'b0;
    m_low = 1'b0;
    wait_clk(6);
    check("ack_before_rst", sda, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("sda_rel_on_rst", sda, 1);
    wait_clk(2);
    rst = 1'b0;
    check("rst2_busy", busy, 0);
    check("rst2_wr_idx", wr_idx, 0);
    check("rst2_wr_dat", wr_dat, 0);
    scl = 1'b1;
    wait_clk(10);
    m_stop;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    for (int i = 0; i < NUM_REGS; i++) check_local(i, m_regs[i]);
    do_read(0, 8'h00, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
